// File: rtl/mult_arbiter.sv
// Round-robin front end for one shared 16x16 sequential multiplier.
// Grants one requester at a time, launches the multiplier with a one-cycle
// start pulse, waits for the busy high/low handshake, and returns the product
// with a one-cycle response pulse. If the multiplier never raises busy, the
// request finishes with an error flag and a zero product.
module mult_arbiter #(
    parameter int NREQ      = 4,
    parameter int START_TMO = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_p,
    output logic                 rsp_err,
    output logic [15:0]          mult_a,
    output logic [15:0]          mult_b,
    output logic                 mult_start,
    input  logic                 mult_busy,
    input  logic [31:0]          mult_p
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(START_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;  // also the owner of the op in flight
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [31:0]     p_q, p_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic            any_req;
    logic [GW-1:0]   pick;
    logic            tmo_hit;

    // Round-robin search starting one past the last grant; the lowest offset wins.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [GW-1:0]   last);
        logic [GW-1:0] sel;
        int            idx;
        sel = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NREQ;
            if (v[idx]) sel = GW'(idx);
        end
        return sel;
    endfunction

    // Arbitration view of the current requests.
    always_comb begin
        any_req = |req_valid;
        pick    = rr_pick(req_valid, last_grant_q);
    end

    // Timeout fires on the last WAIT_HI cycle, so RESP lands START_TMO cycles after START.
    always_comb begin
        tmo_hit = (tmo_cnt_q >= TW'(START_TMO - 1));
    end

    // State register plus datapath flops; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            p_q          <= '0;
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            p_q          <= p_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state logic. Busy is only sampled from WAIT_HI onward, so a busy
    // level left over while idle is never mistaken for a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_req) state_d = S_START;
            S_START:   state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (mult_busy)    state_d = S_WAIT_LO;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_WAIT_LO: if (!mult_busy) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath updates: operands latched at grant and held until the product is taken.
    always_comb begin
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        p_d          = p_q;
        err_d        = err_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    last_grant_d = pick;
                    a_d          = req_a[pick*16 +: 16];
                    b_d          = req_b[pick*16 +: 16];
                end
            end
            S_START: begin
                tmo_cnt_d = TW'(1);
            end
            S_WAIT_HI: begin
                if (!mult_busy) begin
                    if (tmo_hit) begin
                        err_d = 1'b1;
                        p_d   = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
            end
            S_WAIT_LO: begin
                if (!mult_busy) begin
                    err_d = 1'b0;
                    p_d   = mult_p;
                end
            end
            S_RESP: begin
                tmo_cnt_d = '0;
            end
            default: begin
                tmo_cnt_d = '0;
            end
        endcase
    end

    // Moore outputs from state, except the grant pulse which follows the live request.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        mult_start = 1'b0;
        rsp_err    = 1'b0;
        case (state_q)
            S_IDLE:  if (any_req && !rst) req_ready[pick] = 1'b1;
            S_START: mult_start = 1'b1;
            S_RESP: begin
                rsp_valid[last_grant_q] = 1'b1;
                rsp_err                 = err_q;
            end
            default: ;
        endcase
    end

    assign mult_a = a_q;
    assign mult_b = b_q;
    assign rsp_p  = p_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and random checks for mult_arbiter against a behavioural
// sequential multiplier.
module tb_mult_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*16-1:0]  req_a, req_b;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [31:0]         rsp_p;
    logic                rsp_err;
    logic [15:0]         mult_a, mult_b;
    logic                mult_start;
    logic                mult_busy;
    logic [31:0]         mult_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rsp_cyc = 0;
    int n_start = 0;
    int multihot = 0;

    // multiplier model controls
    int   m_dly = 0;
    bit   no_busy = 1'b0;
    int   m_ph, m_cnt;
    logic m_busy;
    logic [31:0] m_p;

    mult_arbiter #(.NREQ(NREQ), .START_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_p(rsp_p), .rsp_err(rsp_err),
        .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
        .mult_busy(mult_busy), .mult_p(mult_p)
    );

    always #5 clk = ~clk;

    assign mult_busy = m_busy;
    assign mult_p    = m_p;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared multiplier: busy rises m_dly+1 cycles after start, stays 4 cycles,
    // product (from the operands still presented) appears as busy falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_cnt <= 0; m_busy <= 1'b0; m_p <= '0;
        end else begin
            case (m_ph)
                0: if (mult_start && !no_busy) begin m_ph <= 1; m_cnt <= m_dly; end
                1: if (m_cnt == 0) begin m_busy <= 1'b1; m_ph <= 2; m_cnt <= 3; end
                   else m_cnt <= m_cnt - 1;
                default: if (m_cnt == 0) begin
                       m_busy <= 1'b0;
                       m_p    <= $signed(mult_a) * $signed(mult_b);
                       m_ph   <= 0;
                   end else m_cnt <= m_cnt - 1;
            endcase
        end
    end

    // Start-pulse counter and multi-hot watch.
    always @(negedge clk) begin
        if (mult_start === 1'b1) begin n_start++; start_cyc = cyc; end
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) multihot++;
    end

    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input int exp_p, input bit exp_err, input string nm);
        int n;
        int s0;
        logic [NREQ-1:0] exp_oh;
        exp_oh = NREQ'(1) << idx;
        @(negedge clk);
        s0 = n_start;
        req_valid[idx] = 1'b1;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        #1; n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (req_ready !== exp_oh) begin
            errors++; $display("FAIL %s ready: got %b want %b", nm, req_ready, exp_oh);
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        req_a[idx*16 +: 16] = ~a;
        req_b[idx*16 +: 16] = ~b;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin @(negedge clk); n++; end
        rsp_cyc = cyc;
        checks++;
        if (rsp_valid !== exp_oh) begin
            errors++; $display("FAIL %s rsp_valid: got %b want %b", nm, rsp_valid, exp_oh);
        end
        checks++;
        if (rsp_p !== exp_p[31:0]) begin
            errors++; $display("FAIL %s rsp_p: got %0d want %0d", nm, $signed(rsp_p), exp_p);
        end
        checks++;
        if (rsp_err !== exp_err) begin
            errors++; $display("FAIL %s rsp_err: got %b want %b", nm, rsp_err, exp_err);
        end
        checks++;
        if (n_start - s0 != 1) begin
            errors++; $display("FAIL %s start_pulses: got %0d want 1", nm, n_start - s0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mult_start, mult_a, mult_b, rsp_p} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rv=%b err=%b st=%b a=%h b=%h p=%h want all 0",
                     req_ready, rsp_valid, rsp_err, mult_start, mult_a, mult_b, rsp_p);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        run_op(2, -16'sd3, 16'sd7, -21, 1'b0, "single");
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_p !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL rsp_p_hold: got %h want ffffffeb", rsp_p);
        end
    endtask

    task automatic test_boundary();
        run_op(1, 16'h8000, 16'h8000, 1073741824, 1'b0, "bound_minmin");
        run_op(3, 16'h7FFF, 16'h8000, -1073709056, 1'b0, "bound_maxmin");
    endtask

    task automatic test_round_robin();
        int a_v[4]   = '{100, -200, 300, -400};
        int b_v[4]   = '{5, 6, -7, 8};
        int exp_p[4] = '{500, -1200, -2100, -3200};
        int g, r, n;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = a_v[i][15:0];
            req_b[i*16 +: 16] = b_v[i][15:0];
        end
        req_valid = '1;
        g = 0; r = 0; n = 0;
        while (r < 8 && n < 300) begin
            #1;
            if (req_ready != '0) begin
                oh = NREQ'(1) << (g % 4);
                checks++;
                if (req_ready !== oh) begin
                    errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, oh);
                end
                g++;
            end
            if (rsp_valid != '0) begin
                oh = NREQ'(1) << (r % 4);
                checks++;
                if (rsp_valid !== oh || rsp_p !== exp_p[r % 4][31:0]) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: got %b/%0d want %b/%0d", r, rsp_valid,
                             $signed(rsp_p), oh, exp_p[r % 4]);
                end
                r++;
                if (r == 8) req_valid = '0;
            end
            @(negedge clk); n++;
        end
        req_valid = '0;
        checks++;
        if (g != 8 || r != 8) begin
            errors++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 8/8", g, r);
        end
    endtask

    task automatic test_timeout();
        int d;
        no_busy = 1'b1;
        run_op(0, 16'd5, 16'd6, 0, 1'b1, "timeout");
        d = rsp_cyc - start_cyc;
        checks++;
        if (d < TMO - 1 || d > TMO + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d want %0d+-1", d, TMO);
        end
        no_busy = 1'b0;
        run_op(1, 16'd5, 16'd6, 30, 1'b0, "after_timeout");
    endtask

    task automatic test_reset_mid();
        int n, seen;
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_a[2*16 +: 16] = 16'd9;
        req_b[2*16 +: 16] = 16'd9;
        #1; n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (m_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (m_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy_seen: got %b want 1", m_busy);
        end
        @(negedge clk);   // DUT now in WAIT_LO
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mult_start, mult_a, mult_b, rsp_p} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rv=%b err=%b st=%b a=%h b=%h p=%h want all 0",
                     rsp_valid, rsp_err, mult_start, mult_a, mult_b, rsp_p);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rstmid_no_rsp: got %0d pulses want 0", seen);
        end
        req_a[0 +: 16]  = -16'sd5;
        req_b[0 +: 16]  = -16'sd5;
        req_a[48 +: 16] = 16'd1;
        req_b[48 +: 16] = 16'd1;
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rstmid_first_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 32'd25) begin
            errors++; $display("FAIL rstmid_rsp: got %b/%0d want 0001/25", rsp_valid, $signed(rsp_p));
        end
    endtask

    task automatic test_random();
        int idx, ep;
        logic [15:0] a, b;
        for (int k = 0; k < 300; k++) begin
            idx   = $urandom_range(0, NREQ - 1);
            a     = 16'($urandom);
            b     = 16'($urandom);
            m_dly = $urandom_range(0, 3);
            ep    = int'($signed(a)) * int'($signed(b));
            run_op(idx, a, b, ep, 1'b0, "random");
        end
        checks++;
        if (multihot != 0) begin
            errors++; $display("FAIL multihot: got %0d events want 0", multihot);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
